// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int X_LENGTH = 32;

  localparam logic [X_LENGTH-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [X_LENGTH-1:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [X_LENGTH-1:0] pc;
    logic [X_LENGTH-1:0] instruction;
  } fetch_entry_t;

  // Word-align an address by clearing the two byte-offset bits.
  function automatic logic [X_LENGTH-1:0] align_pc(input logic [X_LENGTH-1:0] addr);
    return {addr[X_LENGTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a single-cycle flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  fetch_entry_t      push_data,
  input  logic              pop,
  output fetch_entry_t      head_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state for storage, pointers and count; flush overrides everything.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and count registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch front end: owns the PC, pairs ROM words with their PC, queues
// them toward decode and applies redirects from execute.
// QUEUE_DEPTH must be a power of two and at least 2.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter  logic [X_LENGTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter  int                  QUEUE_DEPTH  = 4,
  localparam int                  CNT_W        = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic [X_LENGTH-1:0] pc,
  input  logic [X_LENGTH-1:0] instruction,
  input  logic                redirect_valid,
  input  logic [X_LENGTH-1:0] redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [X_LENGTH-1:0] out_pc,
  output logic [X_LENGTH-1:0] out_instruction,
  output logic [CNT_W-1:0]    occupancy
);

  logic [X_LENGTH-1:0] pc_q, pc_d;
  logic                inflight_q, inflight_d;
  logic [X_LENGTH-1:0] inflight_pc_q, inflight_pc_d;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  fetch_entry_t     fifo_head;
  fetch_entry_t     capture_entry;

  logic [CNT_W-1:0] credits_used;
  logic             issue;
  logic             capture;
  logic             consume;

  // A slot is reserved for every outstanding fetch, so a returning word
  // always finds room in the queue.
  assign credits_used = fifo_count + CNT_W'(inflight_q);
  assign issue        = !redirect_valid && (credits_used < CNT_W'(QUEUE_DEPTH));
  assign capture      = inflight_q && !redirect_valid;
  assign consume      = out_valid && out_ready && !redirect_valid;

  assign capture_entry.pc          = inflight_pc_q;
  assign capture_entry.instruction = instruction;

  fetch_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (capture),
    .push_data (capture_entry),
    .pop       (consume),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Outputs come straight from registers; an empty queue presents a NOP at PC 0.
  assign pc              = pc_q;
  assign out_valid       = !fifo_empty;
  assign out_pc          = fifo_empty ? '0 : fifo_head.pc;
  assign out_instruction = fifo_empty ? NOP_INSTR : fifo_head.instruction;
  assign occupancy       = fifo_count;

  // PC and in-flight tracking; a redirect discards the pending word and
  // restarts at the aligned target without issuing in the same cycle.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end else if (issue) begin
      pc_d          = pc_q + PC_STEP;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  // PC and in-flight registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_VECTOR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

endmodule
